// File: rtl/rib_arbiter_pkg.sv
// Shared constants and types for the RIB bus arbiter.
package rib_arbiter_pkg;

  localparam int NUM_MST = 4;

  // Master indices; master 3 is the debug port that may take priority.
  localparam logic [1:0] MST_0   = 2'd0;
  localparam logic [1:0] MST_1   = 2'd1;
  localparam logic [1:0] MST_2   = 2'd2;
  localparam logic [1:0] MST_DBG = 2'd3;

  localparam int MAX_HOLD_DEF = 16;

  // grant_o value out of reset; master 1 never stalls the core.
  localparam logic [1:0] GRANT_RST = MST_1;

  // Levels of the stall request towards the core.
  localparam logic HOLD_ENABLE  = 1'b1;
  localparam logic HOLD_DISABLE = 1'b0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  // Result of one round-robin search.
  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } pick_t;

  // One-hot select for a master index.
  function automatic logic [NUM_MST-1:0] mst_bit(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rib_arbiter_rr_pick4.sv
// Combinational 4-way round-robin priority encoder.
// Candidates are req_i & mask_i; the search starts at ptr_i and wraps 3->0.
module rr_pick4
  import rib_arbiter_pkg::*;
(
  input  logic [NUM_MST-1:0] req_i,
  input  logic [NUM_MST-1:0] mask_i,
  input  logic [1:0]         ptr_i,
  output pick_t              pick_o
);

  logic [NUM_MST-1:0] cand;
  logic [1:0]         idx;

  // Walk offsets from farthest to nearest so the candidate closest to ptr_i wins.
  always_comb begin
    cand   = req_i & mask_i;
    pick_o = '0;
    idx    = '0;
    for (int k = NUM_MST - 1; k >= 0; k--) begin
      idx = ptr_i + 2'(k);
      if (cand[idx]) begin
        pick_o.vld = 1'b1;
        pick_o.idx = idx;
      end
    end
  end

endmodule

// File: rtl/rib_arbiter.sv
// RIB bus arbiter: round-robin grant among four masters with optional debug
// priority, locked multi-beat ownership and a hold-time limit under contention.
// MAX_HOLD must lie in 1..16 because the hold counter is 4 bits wide.
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter bit PRIO_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_MST-1:0] req_i,
  input  logic [NUM_MST-1:0] lock_i,
  output logic [1:0]         grant_o,
  output logic               grant_valid_o,
  output logic               hold_flag_o,
  output logic               timeout_o
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] last_q, last_d;
  logic [3:0] cnt_q, cnt_d;

  logic               own;
  logic [NUM_MST-1:0] others;
  logic               force_rel;
  logic               release_pt;
  logic               arb_pt;
  logic [NUM_MST-1:0] mask;
  logic [1:0]         ptr;
  logic               prio_hit;
  logic [1:0]         winner;
  pick_t              pick;

  // Release / arbitration-point decode; the current owner never competes at
  // its own release, which also keeps a force-released master out.
  always_comb begin
    own        = (state_q == ST_OWN);
    others     = req_i & ~mst_bit(grant_q);
    force_rel  = own && (cnt_q == HOLD_LAST) && (|others);
    release_pt = own && (!req_i[grant_q] || !lock_i[grant_q] || force_rel);
    arb_pt     = !own || release_pt;
    mask       = own ? ~mst_bit(grant_q) : '1;
    ptr        = last_q + 2'd1;
  end

  rr_pick4 u_pick (
    .req_i  (req_i),
    .mask_i (mask),
    .ptr_i  (ptr),
    .pick_o (pick)
  );

  // Next-state: new grant at an arbitration point, else count owned cycles.
  always_comb begin
    prio_hit = PRIO_EN && req_i[MST_DBG] && mask[MST_DBG];
    winner   = prio_hit ? MST_DBG : pick.idx;
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    if (arb_pt) begin
      if (pick.vld) begin
        state_d = ST_OWN;
        grant_d = winner;
        last_d  = winner;
        cnt_d   = '0;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (cnt_q != HOLD_LAST) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // State registers; grant_q keeps its value through IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= GRANT_RST;
      last_q  <= MST_0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stall the core for any master but 1 requesting or owning the bus.
  always_comb begin
    hold_flag_o = HOLD_DISABLE;
    if (req_i[MST_0] || req_i[MST_2] || req_i[MST_DBG] || (own && grant_q != MST_1))
      hold_flag_o = HOLD_ENABLE;
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = own;
  assign timeout_o     = force_rel;

endmodule
